// File: rtl/ascon_fsm.sv
// -----------------------------------------------------------------------------
// ascon_fsm
// Control sequencer for an ASCON-128 permutation datapath (one round per cycle).
// Runs initialisation (p^a), one associated-data block (p^b), any number of
// plaintext blocks (p^b) and finalisation (p^a). It owns the upstream data
// handshake and signals when the cipher and tag registers hold valid values.
//
// Ports
//   clock, reset_n            clock and synchronous active-low reset
//   i_start                   begin a new operation (IDLE/DONE only)
//   i_data_valid              AD/PT block present on the datapath data input
//   i_last_block              marks the current PT transfer as the final block
//   o_data_ready              a block is accepted this cycle when valid is high
//   o_sys_enable              datapath enable (0 soft-clears the datapath)
//   o_mux_select              0 = load external state, 1 = feed back state reg
//   o_enable_*                per-cycle datapath strobes
//   o_round                   round index for the constant-addition layer
//   o_cipher_valid            one-cycle pulse after each PT block is accepted
//   o_block_count             PT blocks accepted since start (wraps)
//   o_busy / o_done           operation in progress / tag register valid
// -----------------------------------------------------------------------------
module ascon_fsm #(
   parameter int ROUNDS_A  = 12,
   parameter int ROUNDS_B  = 6,
   parameter int BLK_CNT_W = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic                 i_data_valid,
   input  logic                 i_last_block,
   output logic                 o_data_ready,
   output logic                 o_sys_enable,
   output logic                 o_mux_select,
   output logic                 o_enable_xor_key_begin,
   output logic                 o_enable_xor_data_begin,
   output logic                 o_enable_xor_key_end,
   output logic                 o_enable_xor_lsb_end,
   output logic                 o_enable_cipher_reg,
   output logic                 o_enable_tag_reg,
   output logic                 o_enable_state_reg,
   output logic [3:0]           o_round,
   output logic                 o_cipher_valid,
   output logic [BLK_CNT_W-1:0] o_block_count,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam logic [3:0] RND_FIRST_A = 4'd0;
   localparam logic [3:0] RND_LAST    = 4'(ROUNDS_A - 1);
   localparam logic [3:0] RND_FIRST_B = 4'(ROUNDS_A - ROUNDS_B);
   localparam logic [3:0] RND_ONE     = 4'd1;
   localparam logic [BLK_CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [BLK_CNT_W-1:0] CNT_ONE  = BLK_CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_WAIT_AD = 3'd2,
      S_AD      = 3'd3,
      S_WAIT_PT = 3'd4,
      S_PT      = 3'd5,
      S_FINAL   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             rnd_q, rnd_d;
   logic [BLK_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   cv_q, cv_d;

   // Next-state logic and per-cycle datapath strobes. The accept cycle in the
   // WAIT states is combinational on i_data_valid: it already is the first
   // round of the block, so the round index and XOR strobes depend on it.
   always_comb begin
      state_d                 = state_q;
      rnd_d                   = rnd_q;
      cnt_d                   = cnt_q;
      cv_d                    = 1'b0;
      o_data_ready            = 1'b0;
      o_sys_enable            = 1'b0;
      o_mux_select            = 1'b0;
      o_enable_xor_key_begin  = 1'b0;
      o_enable_xor_data_begin = 1'b0;
      o_enable_xor_key_end    = 1'b0;
      o_enable_xor_lsb_end    = 1'b0;
      o_enable_cipher_reg     = 1'b0;
      o_enable_tag_reg        = 1'b0;
      o_enable_state_reg      = 1'b0;
      o_round                 = 4'd0;
      o_busy                  = 1'b0;
      o_done                  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               o_sys_enable = 1'b1;   // keep tag and cipher registers alive
               o_done       = 1'b1;
            end else begin
               o_sys_enable = 1'b0;
            end
            if (i_start) begin
               state_d = S_INIT;
               rnd_d   = RND_FIRST_A;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = state_q;
            end
         end
         S_INIT: begin
            o_busy             = 1'b1;
            o_sys_enable       = 1'b1;
            o_enable_state_reg = 1'b1;
            o_round            = rnd_q;
            // first init round loads the external key/nonce/IV state
            o_mux_select       = (rnd_q != RND_FIRST_A);
            if (rnd_q == RND_LAST) begin
               o_enable_xor_key_end = 1'b1;
               state_d              = S_WAIT_AD;
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end
         S_WAIT_AD, S_WAIT_PT: begin
            o_busy       = 1'b1;
            o_data_ready = 1'b1;
            o_sys_enable = 1'b1;
            o_mux_select = 1'b1;
            o_round      = rnd_q;
            if (i_data_valid) begin
               o_enable_xor_data_begin = 1'b1;
               o_enable_state_reg      = 1'b1;
               if (state_q == S_WAIT_AD) begin
                  o_round = RND_FIRST_B;
                  state_d = S_AD;
                  rnd_d   = RND_FIRST_B + RND_ONE;
               end else begin
                  o_enable_cipher_reg = 1'b1;
                  cv_d                = 1'b1;
                  cnt_d               = cnt_q + CNT_ONE;
                  if (i_last_block) begin
                     // last block rolls straight into the p^a finalisation
                     o_enable_xor_key_begin = 1'b1;
                     o_round                = RND_FIRST_A;
                     state_d                = S_FINAL;
                     rnd_d                  = RND_FIRST_A + RND_ONE;
                  end else begin
                     o_round = RND_FIRST_B;
                     state_d = S_PT;
                     rnd_d   = RND_FIRST_B + RND_ONE;
                  end
               end
            end else begin
               o_enable_state_reg = 1'b0;
            end
         end
         S_AD, S_PT: begin
            o_busy             = 1'b1;
            o_sys_enable       = 1'b1;
            o_mux_select       = 1'b1;
            o_enable_state_reg = 1'b1;
            o_round            = rnd_q;
            if (rnd_q == RND_LAST) begin
               o_enable_xor_lsb_end = (state_q == S_AD);  // domain separation
               state_d              = S_WAIT_PT;
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end
         S_FINAL: begin
            o_busy             = 1'b1;
            o_sys_enable       = 1'b1;
            o_mux_select       = 1'b1;
            o_enable_state_reg = 1'b1;
            o_round            = rnd_q;
            if (rnd_q == RND_LAST) begin
               o_enable_xor_key_end = 1'b1;
               o_enable_tag_reg     = 1'b1;
               state_d              = S_DONE;
               rnd_d                = RND_FIRST_A;
            end else begin
               rnd_d = rnd_q + RND_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            rnd_d   = RND_FIRST_A;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State, round, block-count and cipher-valid registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rnd_q   <= RND_FIRST_A;
         cnt_q   <= CNT_ZERO;
         cv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         cnt_q   <= cnt_d;
         cv_q    <= cv_d;
      end
   end

   assign o_cipher_valid = cv_q;
   assign o_block_count  = cnt_q;

endmodule

// File: tb/tb_ascon_fsm.sv
// -----------------------------------------------------------------------------
// tb_ascon_fsm
// Directed bench for ascon_fsm. A checkpoint table describes the full flow
// (init, one AD block, four PT blocks), followed by hand-written sequences for
// stall, restart, mid-operation reset and block-counter wrap (2-bit instance).
// -----------------------------------------------------------------------------
module tb_ascon_fsm;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       i_start, i_data_valid, i_last_block;
   logic       o_data_ready, o_sys_enable, o_mux_select;
   logic       o_enable_xor_key_begin, o_enable_xor_data_begin;
   logic       o_enable_xor_key_end, o_enable_xor_lsb_end;
   logic       o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg;
   logic [3:0] o_round;
   logic       o_cipher_valid, o_busy, o_done;
   logic [7:0] o_block_count;

   // narrow-counter instance for the wrap check; shares all inputs
   logic       w_data_ready, w_sys_enable, w_mux_select;
   logic       w_xkb, w_xdb, w_xke, w_xle, w_cr, w_tr, w_sr;
   logic [3:0] w_round;
   logic       w_cipher_valid, w_busy, w_done;
   logic [1:0] w_block_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   ascon_fsm dut (
      .clock(clock), .reset_n(reset_n), .i_start(i_start),
      .i_data_valid(i_data_valid), .i_last_block(i_last_block),
      .o_data_ready(o_data_ready), .o_sys_enable(o_sys_enable),
      .o_mux_select(o_mux_select),
      .o_enable_xor_key_begin(o_enable_xor_key_begin),
      .o_enable_xor_data_begin(o_enable_xor_data_begin),
      .o_enable_xor_key_end(o_enable_xor_key_end),
      .o_enable_xor_lsb_end(o_enable_xor_lsb_end),
      .o_enable_cipher_reg(o_enable_cipher_reg),
      .o_enable_tag_reg(o_enable_tag_reg),
      .o_enable_state_reg(o_enable_state_reg),
      .o_round(o_round), .o_cipher_valid(o_cipher_valid),
      .o_block_count(o_block_count), .o_busy(o_busy), .o_done(o_done)
   );

   ascon_fsm #(.BLK_CNT_W(2)) dut_w (
      .clock(clock), .reset_n(reset_n), .i_start(i_start),
      .i_data_valid(i_data_valid), .i_last_block(i_last_block),
      .o_data_ready(w_data_ready), .o_sys_enable(w_sys_enable),
      .o_mux_select(w_mux_select),
      .o_enable_xor_key_begin(w_xkb), .o_enable_xor_data_begin(w_xdb),
      .o_enable_xor_key_end(w_xke), .o_enable_xor_lsb_end(w_xle),
      .o_enable_cipher_reg(w_cr), .o_enable_tag_reg(w_tr),
      .o_enable_state_reg(w_sr), .o_round(w_round),
      .o_cipher_valid(w_cipher_valid), .o_block_count(w_block_count),
      .o_busy(w_busy), .o_done(w_done)
   );

   typedef struct {
      int          cyc;
      logic [16:0] ctl;
      logic [7:0]  cnt;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];
   logic [1:0] wrap_exp[5];

   // expected control word: {ready,sys,mux,xkb,xdb,xke,xle,cr,tr,sr,round,cv,busy,done}
   function automatic logic [16:0] mk(input bit rdy, input bit sys, input bit mux,
                                      input bit xkb, input bit xdb, input bit xke,
                                      input bit xle, input bit cr, input bit tr,
                                      input bit sr, input logic [3:0] rnd,
                                      input bit cv, input bit busy, input bit done);
      return {rdy, sys, mux, xkb, xdb, xke, xle, cr, tr, sr, rnd, cv, busy, done};
   endfunction

   function automatic logic [16:0] get_ctl();
      return {o_data_ready, o_sys_enable, o_mux_select, o_enable_xor_key_begin,
              o_enable_xor_data_begin, o_enable_xor_key_end, o_enable_xor_lsb_end,
              o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg,
              o_round, o_cipher_valid, o_busy, o_done};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // hold valid until the FSM is ready, let the accept edge pass, then drop it
   task automatic accept_block(input logic last);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         i_data_valid = 1'b1;
         i_last_block = last;
         #2;
         seen = o_data_ready;
         tick();
      end
      i_data_valid = 1'b0;
      i_last_block = 1'b0;
      check("ready_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            cyc  rdy sys mux xkb xdb xke xle cr tr sr rnd  cv busy done   cnt
      vecs[0]  = '{0,  mk(0,0,0,0,0,0,0,0,0,0,4'd0, 0,0,0), 8'd0};
      vecs[1]  = '{1,  mk(0,1,0,0,0,0,0,0,0,1,4'd0, 0,1,0), 8'd0};
      vecs[2]  = '{2,  mk(0,1,1,0,0,0,0,0,0,1,4'd1, 0,1,0), 8'd0};
      vecs[3]  = '{12, mk(0,1,1,0,0,1,0,0,0,1,4'd11,0,1,0), 8'd0};
      vecs[4]  = '{13, mk(1,1,1,0,1,0,0,0,0,1,4'd6, 0,1,0), 8'd0};
      vecs[5]  = '{14, mk(0,1,1,0,0,0,0,0,0,1,4'd7, 0,1,0), 8'd0};
      vecs[6]  = '{18, mk(0,1,1,0,0,0,1,0,0,1,4'd11,0,1,0), 8'd0};
      vecs[7]  = '{19, mk(1,1,1,0,1,0,0,1,0,1,4'd6, 0,1,0), 8'd0};
      vecs[8]  = '{20, mk(0,1,1,0,0,0,0,0,0,1,4'd7, 1,1,0), 8'd1};
      vecs[9]  = '{22, mk(0,1,1,0,0,0,0,0,0,1,4'd9, 0,1,0), 8'd1};
      vecs[10] = '{23, mk(0,1,1,0,0,0,0,0,0,1,4'd10,0,1,0), 8'd1};
      vecs[11] = '{25, mk(1,1,1,0,1,0,0,1,0,1,4'd6, 0,1,0), 8'd1};
      vecs[12] = '{26, mk(0,1,1,0,0,0,0,0,0,1,4'd7, 1,1,0), 8'd2};
      vecs[13] = '{37, mk(1,1,1,1,1,0,0,1,0,1,4'd0, 0,1,0), 8'd3};
      vecs[14] = '{38, mk(0,1,1,0,0,0,0,0,0,1,4'd1, 1,1,0), 8'd4};
      vecs[15] = '{48, mk(0,1,1,0,0,1,0,0,1,1,4'd11,0,1,0), 8'd4};
      vecs[16] = '{49, mk(0,1,0,0,0,0,0,0,0,0,4'd0, 0,0,1), 8'd4};
      vecs[17] = '{50, mk(0,1,0,0,0,0,0,0,0,0,4'd0, 0,0,1), 8'd4};
      wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // reset: two cycles low, everything idle
      reset_n = 1'b0; i_start = 1'b0; i_data_valid = 1'b0; i_last_block = 1'b0;
      tick();
      tick();
      check("reset_ctl", 32'(get_ctl()), 32'd0);
      check("reset_cnt", 32'(o_block_count), 32'd0);
      reset_n = 1'b1;

      // full flow: valid held high (also during INIT), stray start in PT
      for (int c = 0; c <= 50; c++) begin
         i_start      = (c == 0) || (c == 22);
         i_data_valid = 1'b1;
         i_last_block = (c == 37);
         #2;
         for (int k = 0; k < NV; k++) begin
            if (vecs[k].cyc == c) begin
               check($sformatf("flow_ctl_c%0d", c), 32'(get_ctl()), 32'(vecs[k].ctl));
               check($sformatf("flow_cnt_c%0d", c), 32'(o_block_count), 32'(vecs[k].cnt));
            end
         end
         tick();
      end
      check("wrap4_cnt", 32'(w_block_count), 32'd0);

      // restart from DONE: INIT round 0, count cleared
      i_start = 1'b1; i_data_valid = 1'b0; i_last_block = 1'b0;
      tick();
      i_start = 1'b0;
      #2;
      check("restart_ctl", 32'(get_ctl()), 32'(mk(0,1,0,0,0,0,0,0,0,1,4'd0,0,1,0)));
      check("restart_cnt", 32'(o_block_count), 32'd0);

      // stall in WAIT_PT for 5 cycles, then resume
      accept_block(1'b0);            // AD block; now in AD rnd 7
      for (int i = 0; i < 5; i++) tick();
      for (int s = 0; s < 5; s++) begin
         i_data_valid = 1'b0;
         #2;
         check($sformatf("stall_ctl_%0d", s), 32'(get_ctl()),
               32'(mk(1,1,1,0,0,0,0,0,0,0,4'd11,0,1,0)));
         tick();
      end
      i_data_valid = 1'b1;
      #2;
      check("resume_accept", 32'(get_ctl()), 32'(mk(1,1,1,0,1,0,0,1,0,1,4'd6,0,1,0)));
      tick();
      i_data_valid = 1'b0;
      #2;
      check("resume_pt7", 32'(get_ctl()), 32'(mk(0,1,1,0,0,0,0,0,0,1,4'd7,1,1,0)));
      check("resume_cnt", 32'(o_block_count), 32'd1);
      tick();
      tick();
      #2;
      check("pt_rnd9", 32'(o_round), 32'd9);

      // reset in PT at round 9
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #2;
      check("midreset_ctl", 32'(get_ctl()), 32'd0);
      check("midreset_cnt", 32'(o_block_count), 32'd0);
      tick();

      // wrap: five PT blocks on the 2-bit counter
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      accept_block(1'b0);
      for (int b = 0; b < 5; b++) begin
         accept_block(b == 4);
         #2;
         check($sformatf("wrap_cnt_%0d", b), 32'(w_block_count), 32'(wrap_exp[b]));
      end
      begin
         bit got_done = 1'b0;
         for (int i = 0; i < 40 && !got_done; i++) begin
            #2;
            got_done = o_done;
            if (!got_done) tick();
         end
         check("wrap_done", 32'(got_done), 32'd1);
         check("wrap_cnt8", 32'(o_block_count), 32'd5);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
